// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and types for the instruction-fetch stage
package if_fetch_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic Ready = 1'b1;
  localparam logic Stop = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam int InstrAddrBus = 32;
  localparam int InstrBus = 32;
  typedef enum logic {IDLE, BUSY} fetch_state_e;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: req/ack fetch bus between the fetch stage and the memory controller
interface if_fetch_if import if_fetch_pkg::*; #(
  parameter int ADDR_W = InstrAddrBus
);
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_ack;
  logic [InstrBus-1:0] mem_data;
  modport master (output mem_req, mem_addr, input mem_ack, mem_data);
  modport slave (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/if_icache.sv
// if_icache: direct-mapped one-word-per-line instruction cache, comb read, sync write
module if_icache import if_fetch_pkg::*; #(
  parameter int IDX_W = 6,
  parameter int ADDR_W = InstrAddrBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                hit,
  output logic [InstrBus-1:0] rd_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [InstrBus-1:0] wr_data
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [InstrBus-1:0] data_q [LINES];
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic unused_ok;
  assign rd_idx = rd_addr[IDX_W+1:2];
  assign wr_idx = wr_addr[IDX_W+1:2];
  assign hit = valid_q[rd_idx] && tag_q[rd_idx] == rd_addr[ADDR_W-1:IDX_W+2];
  assign rd_data = data_q[rd_idx];
  assign unused_ok = ^{rd_addr[1:0], wr_addr[1:0]};
  // valid bits are the only state cleared by reset; lines never get invalidated otherwise
  always_ff @(posedge clk) begin
    if (rst == RstEnable) valid_q <= '0;
    else if (rdy == Ready && wr_en) valid_q[wr_idx] <= 1'b1;
  end
  // tag and data need no reset since valid gates them
  always_ff @(posedge clk) begin
    if (rst != RstEnable && rdy == Ready && wr_en) begin
      tag_q[wr_idx] <= wr_addr[ADDR_W-1:IDX_W+2];
      data_q[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC register, icache lookup and single-outstanding miss fetch FSM
module if_fetch import if_fetch_pkg::*; #(
  parameter int ADDR_W = InstrAddrBus,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int IDX_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [5:0]          stall,
  input  logic                branch_en,
  input  logic [ADDR_W-1:0]   branch_target,
  if_fetch_if.master          mem,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [InstrBus-1:0] if_instr,
  output logic                stallreq_if
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, fetch_addr_q, fetch_addr_d;
  logic mem_req_q, mem_req_d, hit, fill, issue, unused_ok;
  logic [InstrBus-1:0] rd_data;
  if_icache #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_icache (
    .clk(clk), .rst(rst), .rdy(rdy), .rd_addr(pc_q), .hit(hit), .rd_data(rd_data),
    .wr_en(fill), .wr_addr(fetch_addr_q), .wr_data(mem.mem_data)
  );
  assign fill = state_q == BUSY && mem.mem_ack;
  assign issue = state_q == IDLE && !hit && !branch_en;
  assign mem.mem_req = mem_req_q;
  assign mem.mem_addr = fetch_addr_q;
  assign if_pc = pc_q;
  assign if_instr = hit ? rd_data : '0;
  assign stallreq_if = !hit;
  assign unused_ok = ^{stall[5:1], branch_target[1:0]};
  // next PC: a branch beats stall and miss; otherwise advance only on an unstalled hit
  always_comb begin
    pc_d = branch_en ? {branch_target[ADDR_W-1:2], 2'b00} :
           (stall[0] == NoStop && hit) ? pc_q + ADDR_W'(4) : pc_q;
  end
  // fetch FSM: a fill completes even after a redirect, so the line still lands in the cache
  always_comb begin
    state_d = issue ? BUSY : fill ? IDLE : state_q;
    mem_req_d = issue || (state_q == BUSY && !mem.mem_ack);
    fetch_addr_d = issue ? pc_q : fetch_addr_q;
  end
  // state registers, frozen while not ready
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q <= PC_RESET;
      state_q <= IDLE;
      mem_req_q <= 1'b0;
      fetch_addr_q <= '0;
    end else if (rdy == Ready) begin
      pc_q <= pc_d;
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register. Drives if_pc/if_instr into it.
- Holds the PC and looks instructions up in a small direct-mapped instruction cache.
- On a miss it fetches a 32-bit word from the memory controller over a req/ack handshake and raises stallreq_if to the stall controller.
- Accepts branch redirects from EX.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset.
- IDX_W, 6, cache index width (2^IDX_W one-word lines).
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- stall  in  6  pipeline stall vector; bit0 = PC stage, bit1 = IF stage.
- branch_en  in  1  redirect request from EX.
- branch_target  in  ADDR_W  redirect address; bits [1:0] ignored.
- mem_req  out  1  fetch request, level-held until ack.
- mem_addr  out  ADDR_W  word address of the fetch.
- mem_ack  in  1  one-cycle pulse; mem_data valid this cycle.
- mem_data  in  32  fetched instruction word.
- if_pc  out  ADDR_W  PC of the instruction presented.
- if_instr  out  32  instruction; 0 when not hit.
- stallreq_if  out  1  high while current PC misses.

Behaviour:
- Reset (rst=1 at posedge, regardless of rdy):
  - pc=PC_RESET; all cache valid bits=0; state=IDLE; mem_req=0; mem_addr=0.
- rdy=0: no register, cache or FSM update. mem_req and mem_addr hold their values.
- Address split:
  - index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
  - hit = valid[index] && tag match.
- Combinational outputs:
  - if_pc = pc.
  - if_instr = hit ? data[index] : 32'h0.
  - stallreq_if = !hit.
- PC update, when rdy=1 (priority order):
  - branch_en=1: pc <= {branch_target[ADDR_W-1:2],2'b00}. Wins over stall and miss.
  - else if stall[0]==NoStop && hit: pc <= pc+4, wrapping modulo 2^ADDR_W.
  - else hold.
- Fetch FSM (states IDLE, BUSY), when rdy=1:
  - IDLE: if !hit && !branch_en, latch fetch_addr=pc, assert mem_req, mem_addr=pc, go to BUSY. Otherwise mem_req=0.
  - BUSY: hold mem_req=1 and mem_addr=fetch_addr.
  - BUSY + mem_ack: write data[fetch_addr index]=mem_data, set tag and valid, drop mem_req, go to IDLE.
  - mem_ack in IDLE is ignored.
- Latency:
  - Hit: instruction presented in the same cycle as the PC.
  - Miss: mem_req rises 1 cycle after the PC is set.
  - The cycle after mem_ack, hit=1 and stallreq_if=0.
- Branch while BUSY:
  - The outstanding fetch is completed and filled into the cache (data is valid for fetch_addr); it is never presented.
  - IDLE then re-evaluates the new pc; a miss issues a new request the next cycle.
- Branch to the PC already being fetched: the fill makes it hit, with no extra request.
- Simultaneous branch_en and a cycle where the miss would issue: no request; the new pc is evaluated next cycle.
- Reset while BUSY: FSM returns to IDLE, mem_req drops, and a later stray mem_ack is ignored. The memory controller must also be reset.
- At most one outstanding request at any time.
- The cache is never invalidated except by reset (no self-modifying code support).

Decomposition:
- Shared defines header supplies:
  - RstEnable, Ready, Stop, NoStop.
  - InstrAddrBus, InstrBus widths.
- Sub-module if_icache holds the valid/tag/data arrays:
  - ports: clk, rst, rdy, rd_addr, hit, rd_data, wr_en, wr_addr, wr_data.
  - combinational read, synchronous write.
  - write-then-read to the same index is visible the next cycle.
- if_fetch keeps the PC, FSM and output logic.

Test Plan:
- Reset, then memory returns 32'h00000013 with ack 3 cycles after req:
  - mem_req=1, mem_addr=0 one cycle after reset.
  - stallreq_if=1 until the ack.
  - Next cycle if_pc=0, if_instr=32'h00000013, stallreq_if=0.
  - pc becomes 4 the cycle after.
- Straight-line run over 0x0..0xC twice via branch to 0:
  - First pass: one request per word.
  - Second pass: zero requests and pc advances every cycle.
- stall=6'b000011 held for 4 cycles while hitting:
  - pc and if_instr stable; no mem_req.
  - pc resumes +4 on release.
- branch_en with target 32'h100 during BUSY fetch of 0x8:
  - 0x8 is filled and never presented.
  - Next request has mem_addr=0x100.
  - if_pc=0x100 once hit.
- Alias test with IDX_W=6:
  - Fetch 0x0, then branch to 0x100 (same index 0, different tag).
  - Must miss and refill; a branch back to 0x0 must miss again.
- Extreme cases:
  - rdy=0 for 5 cycles mid-BUSY with mem_ack low: state and mem_req frozen.
  - rst asserted mid-BUSY: mem_req=0 and pc=PC_RESET the next cycle.
  - branch_target=32'h103 yields pc=32'h100.
